dot_product_operand_feeder: RTL

- Initiator and sequencer for the dot-product multiplication unit.
- Buffers up to MAX_LEN operand vector pairs loaded by a host. On a command it issues the unit's start, presents one pair per systolic pass and advances on each pass-done indication.
- Captures the final ReLU output vector when the unit signals done and holds it for the host under a valid/ready handshake.
- Sits between the host/DMA side and the dot-product unit.

---
 rtl/dot_product_operand_feeder_if.sv | 64 ++++++
 rtl/dot_product_operand_feeder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dot_product_operand_feeder_if.sv
// Bundle of host load/command/result channels and the dot-product unit channel
// seen by the operand feeder, plus its debug state.
interface dot_product_operand_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_UNITS  = 4,
  parameter int MAX_LEN    = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int VW    = NUM_UNITS * DATA_WIDTH;

  // Handshakes: a transfer happens on a clock edge where valid && ready are both
  // high; valid never depends on ready, and offered data stays stable until taken.
  logic                 load_valid;
  logic                 load_ready;
  logic [VW-1:0]        load_a;
  logic [VW-1:0]        load_b;
  logic                 load_clear;
  logic [LEN_W-1:0]     fill_count;

  logic                 cmd_go;
  logic [LEN_W-1:0]     cmd_length;
  logic [NUM_UNITS-1:0] cmd_active_units;
  logic [VW-1:0]        cmd_bias;
  logic                 busy;
  logic                 err;
  logic [1:0]           err_code;

  logic                 dpu_clear;
  logic                 dpu_start;
  logic [LEN_W-1:0]     dpu_length;
  logic [NUM_UNITS-1:0] dpu_active_units;
  logic [VW-1:0]        dpu_a;
  logic [VW-1:0]        dpu_b;
  logic [VW-1:0]        dpu_bias;
  logic [NUM_UNITS-1:0] dpu_array_done;
  logic                 dpu_done;
  logic [VW-1:0]        dpu_relu_out;

  logic                 res_valid;
  logic                 res_ready;
  logic [VW-1:0]        res_data;

  logic [2:0]           dbg_state;

  // Environment side: host plus the dot-product unit.
  modport master (
    output load_valid, load_a, load_b, load_clear,
    output cmd_go, cmd_length, cmd_active_units, cmd_bias,
    output dpu_array_done, dpu_done, dpu_relu_out, res_ready,
    input  load_ready, fill_count, busy, err, err_code,
    input  dpu_clear, dpu_start, dpu_length, dpu_active_units, dpu_a, dpu_b, dpu_bias,
    input  res_valid, res_data, dbg_state
  );

  // Feeder side.
  modport slave (
    input  load_valid, load_a, load_b, load_clear,
    input  cmd_go, cmd_length, cmd_active_units, cmd_bias,
    input  dpu_array_done, dpu_done, dpu_relu_out, res_ready,
    output load_ready, fill_count, busy, err, err_code,
    output dpu_clear, dpu_start, dpu_length, dpu_active_units, dpu_a, dpu_b, dpu_bias,
    output res_valid, res_data, dbg_state
  );
endinterface

// File: rtl/dot_product_operand_feeder.sv
// Buffers operand pairs, sequences a dot-product job pass by pass, and holds the
// final ReLU vector for the host; a watchdog aborts a stalled job.
module dot_product_operand_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_UNITS  = 4,
  parameter int MAX_LEN    = 8,
  parameter int TIMEOUT    = 1024
) (
  input logic clk,
  input logic reset,
  dot_product_operand_feeder_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int VW    = NUM_UNITS * DATA_WIDTH;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_KICK  = 3'd2,
    S_FEED  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t               state;
  logic [VW-1:0]        a_mem [MAX_LEN];
  logic [VW-1:0]        b_mem [MAX_LEN];
  logic [LEN_W-1:0]     fill_count;
  logic [LEN_W-1:0]     index;
  logic [TW-1:0]        timer;

  logic                 dpu_clear_r;
  logic                 dpu_start_r;
  logic [LEN_W-1:0]     dpu_length_r;
  logic [NUM_UNITS-1:0] dpu_units_r;
  logic [VW-1:0]        dpu_a_r;
  logic [VW-1:0]        dpu_b_r;
  logic [VW-1:0]        dpu_bias_r;
  logic                 res_valid_r;
  logic [VW-1:0]        res_data_r;
  logic                 err_r;
  logic [1:0]           err_code_r;

  logic                 load_ready_int;
  logic                 load_fire;
  logic                 pass_done;
  logic                 cmd_bad;
  logic [LEN_W-1:0]     index_inc;
  logic [LEN_W-1:0]     feed_idx;

  always_comb begin
    load_ready_int = (state == S_IDLE) && (fill_count < LEN_W'(MAX_LEN));
    load_fire      = bus.load_valid && load_ready_int && !bus.load_clear;
    pass_done      = |bus.dpu_array_done;
    cmd_bad        = (bus.cmd_length == '0) || (bus.cmd_length > fill_count);
    index_inc      = index + LEN_W'(1);
    // The last pass's array_done leaves the index on the final pair.
    feed_idx       = (pass_done && (index_inc < dpu_length_r)) ? index_inc : index;
  end

  // Buffer contents need no reset; fill_count says what is valid.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      a_mem[fill_count[IDX_W-1:0]] <= bus.load_a;
      b_mem[fill_count[IDX_W-1:0]] <= bus.load_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      fill_count   <= '0;
      index        <= '0;
      timer        <= '0;
      dpu_clear_r  <= 1'b0;
      dpu_start_r  <= 1'b0;
      dpu_length_r <= '0;
      dpu_units_r  <= '0;
      dpu_a_r      <= '0;
      dpu_b_r      <= '0;
      dpu_bias_r   <= '0;
      res_valid_r  <= 1'b0;
      res_data_r   <= '0;
      err_r        <= 1'b0;
      err_code_r   <= 2'd0;
    end else begin
      err_r       <= 1'b0;
      dpu_clear_r <= 1'b0;
      dpu_start_r <= 1'b0;
      case (state)
        S_IDLE: begin
          timer <= '0;
          if (bus.load_clear) begin
            fill_count <= '0;
          end else if (load_fire) begin
            fill_count <= fill_count + LEN_W'(1);
          end
          if (bus.cmd_go) begin
            if (cmd_bad) begin
              err_r      <= 1'b1;
              err_code_r <= 2'd1;
            end else begin
              dpu_length_r <= bus.cmd_length;
              dpu_units_r  <= bus.cmd_active_units;
              dpu_bias_r   <= bus.cmd_bias;
              index        <= '0;
              dpu_clear_r  <= 1'b1;
              state        <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          dpu_start_r <= 1'b1;
          dpu_a_r     <= a_mem[0];
          dpu_b_r     <= b_mem[0];
          state       <= S_KICK;
        end
        S_KICK: begin
          state <= S_FEED;
        end
        S_FEED: begin
          // dpu_done outranks a coincident array_done.
          if (bus.dpu_done) begin
            res_data_r  <= bus.dpu_relu_out;
            res_valid_r <= 1'b1;
            timer       <= '0;
            state       <= S_HOLD;
          end else if (pass_done) begin
            timer   <= '0;
            index   <= feed_idx;
            dpu_a_r <= a_mem[feed_idx[IDX_W-1:0]];
            dpu_b_r <= b_mem[feed_idx[IDX_W-1:0]];
          end else if (timer == TW'(TIMEOUT - 1)) begin
            timer       <= '0;
            err_r       <= 1'b1;
            err_code_r  <= 2'd2;
            dpu_clear_r <= 1'b1;
            state       <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_HOLD: begin
          if (bus.res_ready) begin
            res_valid_r <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.load_ready       = load_ready_int;
  assign bus.fill_count       = fill_count;
  assign bus.busy             = (state != S_IDLE);
  assign bus.err              = err_r;
  assign bus.err_code         = err_code_r;
  assign bus.dpu_clear        = dpu_clear_r;
  assign bus.dpu_start        = dpu_start_r;
  assign bus.dpu_length       = dpu_length_r;
  assign bus.dpu_active_units = dpu_units_r;
  assign bus.dpu_a            = dpu_a_r;
  assign bus.dpu_b            = dpu_b_r;
  assign bus.dpu_bias         = dpu_bias_r;
  assign bus.res_valid        = res_valid_r;
  assign bus.res_data         = res_data_r;
  assign bus.dbg_state        = state;
endmodule
